// File: rtl/alu_addsub_seq.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle through a registered carry chain,
// signed/unsigned overflow detection, optional saturation, start/done handshake.
module alu_addsub_seq #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic             signed_mode,
    input  logic             sat_en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             busy,
    output logic             done
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

    if ((CHUNK == 0) || (WIDTH < 2) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("alu_addsub_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e            r_state;
    state_e            w_state_next;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_sum;
    logic              r_sub;
    logic              r_signed;
    logic              r_sat;
    logic              r_carry;
    logic [CntW-1:0]   r_cnt;

    logic [WIDTH-1:0]  r_result;
    logic              r_carry_flag;
    logic              r_overflow;
    logic              r_zero;
    logic              r_negative;
    logic              r_done;

    logic [CHUNK-1:0]  w_a_chunk;
    logic [CHUNK-1:0]  w_b_chunk;
    logic [CHUNK:0]    w_chunk_sum;
    logic [WIDTH-1:0]  w_sum_full;
    logic              w_last;
    logic              w_cout;
    logic              w_msb_cin;
    logic              w_ovf;
    logic [WIDTH-1:0]  w_sat_val;
    logic [WIDTH-1:0]  w_final;

    // Datapath for the chunk selected by the counter
    always_comb begin
        w_a_chunk   = r_a[r_cnt*CHUNK +: CHUNK];
        w_b_chunk   = r_b[r_cnt*CHUNK +: CHUNK];
        w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum_full  = r_sum;
        w_sum_full[r_cnt*CHUNK +: CHUNK] = w_chunk_sum[CHUNK-1:0];
        w_last      = (r_cnt == CntW'(N - 1));
        w_cout      = w_chunk_sum[CHUNK];
    end

    // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin
    always_comb begin
        w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_sum_full[WIDTH-1];
        if (r_signed) begin
            w_ovf = w_msb_cin ^ w_cout;
        end else begin
            w_ovf = r_sub ? ~w_cout : w_cout;
        end
    end

    always_comb begin
        w_sat_val = '0;
        if (r_signed) begin
            w_sat_val = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_sat_val = r_sub ? {WIDTH{1'b0}} : {WIDTH{1'b1}};
        end
        w_final = (r_sat && w_ovf) ? w_sat_val : w_sum_full;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (start) w_state_next = StCalc;
            StCalc:  if (w_last) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_sum        <= '0;
            r_sub        <= 1'b0;
            r_signed     <= 1'b0;
            r_sat        <= 1'b0;
            r_carry      <= 1'b0;
            r_cnt        <= '0;
            r_result     <= '0;
            r_carry_flag <= 1'b0;
            r_overflow   <= 1'b0;
            r_zero       <= 1'b0;
            r_negative   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == StIdle) begin
                if (start) begin
                    r_a      <= a;
                    r_b      <= op_sub ? ~b : b;
                    r_sum    <= '0;
                    r_sub    <= op_sub;
                    r_signed <= signed_mode;
                    r_sat    <= sat_en;
                    r_carry  <= op_sub;
                    r_cnt    <= '0;
                end
            end else begin
                r_sum   <= w_sum_full;
                r_carry <= w_cout;
                r_cnt   <= r_cnt + 1'b1;
                if (w_last) begin
                    r_cnt        <= '0;
                    r_result     <= w_final;
                    r_carry_flag <= w_cout;
                    r_overflow   <= w_ovf;
                    r_zero       <= (w_final == '0);
                    r_negative   <= w_final[WIDTH-1];
                    r_done       <= 1'b1;
                end
            end
        end
    end

    assign result   = r_result;
    assign carry    = r_carry_flag;
    assign overflow = r_overflow;
    assign zero     = r_zero;
    assign negative = r_negative;
    assign busy     = (r_state == StCalc);
    assign done     = r_done;

endmodule
